// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW load/store path.
// The sequencer and its slot picker import everything from here.
package vliw_pkg;

    localparam int NUM_SLOTS  = 4;
    localparam int DATA_W     = 32;
    localparam int MEM_DEPTH  = 1024;
    localparam int SLOT_IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } lsu_seq_state_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lsu_op_t;

endpackage

// File: rtl/lsu_slot_picker.sv
// Combinational lowest-set-bit picker over a pending-slot mask.
// any is high when at least one bit is set; idx is the lowest set position.
module lsu_slot_picker
    import vliw_pkg::*;
#(
    parameter int N     = NUM_SLOTS,
    parameter int IDX_W = SLOT_IDX_W
) (
    input  logic [N-1:0]     mask,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    assign any = |mask;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Serialises the memory ops of one VLIW bundle onto the single LSU port of
// main_memory, one op per cycle in slot order, and returns per-slot load data.
module lsu_mem_sequencer
    import vliw_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bundle_valid,
    output logic                        bundle_ready,
    input  logic [NUM_SLOTS-1:0]        op_valid,
    input  logic [NUM_SLOTS-1:0]        op_we,
    input  logic [NUM_SLOTS*DATA_W-1:0] op_addr,
    input  logic [NUM_SLOTS*DATA_W-1:0] op_wdata,
    output logic                        done,
    output logic [NUM_SLOTS*DATA_W-1:0] rdata,
    output logic [NUM_SLOTS-1:0]        err,
    output logic                        mem_rd_en,
    output logic [DATA_W-1:0]           mem_rd_addr,
    output logic                        mem_wr_en,
    output logic [DATA_W-1:0]           mem_wr_addr,
    output logic [DATA_W-1:0]           mem_wr_data,
    input  logic [DATA_W-1:0]           mem_data_out
);

    lsu_seq_state_e          state_reg;
    lsu_seq_state_e          state_next;
    logic [NUM_SLOTS-1:0]    pend_reg;
    logic [NUM_SLOTS-1:0]    pend_next;
    logic                    rd_pend_reg;
    logic [SLOT_IDX_W-1:0]   rd_slot_reg;

    logic                    pick_any;
    logic [SLOT_IDX_W-1:0]   pick_idx;
    lsu_op_t [NUM_SLOTS-1:0] ops;
    lsu_op_t                 cur_op;

    logic accept;
    logic issue_active;
    logic addr_ok;
    logic issue_rd;
    logic issue_wr;
    logic issue_err;

    assign bundle_ready = (state_reg == IDLE) || (state_reg == DONE);
    assign done         = (state_reg == DONE);
    assign accept       = bundle_valid && bundle_ready;

    lsu_slot_picker #(
        .N     (NUM_SLOTS),
        .IDX_W (SLOT_IDX_W)
    ) u_picker (
        .mask (pend_reg),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign cur_op       = ops[pick_idx];
    assign addr_ok      = cur_op.addr < DATA_W'(MEM_DEPTH);
    assign issue_active = (state_reg == ISSUE) && pick_any;
    assign issue_rd     = issue_active && addr_ok && !cur_op.we;
    assign issue_wr     = issue_active && addr_ok && cur_op.we;
    assign issue_err    = issue_active && !addr_ok;

    // Memory port is driven straight from the picked op so an op issued in
    // cycle t is sampled by main_memory at the end of that same cycle.
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        if (issue_rd) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = cur_op.addr;
        end
        if (issue_wr) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = cur_op.addr;
            mem_wr_data = cur_op.wdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    pend_next  = op_valid;
                    // An empty bundle skips straight to the drain cycle.
                    state_next = (op_valid == '0) ? DRAIN : ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                if (pick_any) begin
                    pend_next[pick_idx] = 1'b0;
                end
                if (pend_next == '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pend_reg    <= '0;
            rd_pend_reg <= 1'b0;
            rd_slot_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pend_reg    <= pend_next;
            rd_pend_reg <= issue_rd;
            rd_slot_reg <= pick_idx;
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        lsu_op_t           op_reg;
        logic [DATA_W-1:0] rdata_reg;
        logic              err_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                op_reg    <= '0;
                rdata_reg <= '0;
                err_reg   <= 1'b0;
            end else if (accept) begin
                op_reg.we    <= op_we[gi];
                op_reg.addr  <= op_addr[gi*DATA_W +: DATA_W];
                op_reg.wdata <= op_wdata[gi*DATA_W +: DATA_W];
                rdata_reg    <= '0;
                err_reg      <= 1'b0;
            end else begin
                // Load data returns one cycle after issue, tagged by rd_slot_reg.
                if (rd_pend_reg && (rd_slot_reg == SLOT_IDX_W'(gi))) begin
                    rdata_reg <= mem_data_out;
                end
                if (issue_err && (pick_idx == SLOT_IDX_W'(gi))) begin
                    err_reg <= 1'b1;
                end
            end
        end

        assign ops[gi]                       = op_reg;
        assign rdata[gi*DATA_W +: DATA_W]    = rdata_reg;
        assign err[gi]                       = err_reg;
    end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer paired with a behavioural main_memory; a queue of
// expected bundle results from a program-order reference model feeds a monitor.
module tb_lsu_mem_sequencer;

    localparam int NS        = 4;
    localparam int DW        = 32;
    localparam int MEM_DEPTH = 1024;

    typedef struct packed {
        logic [31:0]            n;
        logic [NS*DW-1:0]       rdata;
        logic [NS-1:0]          err;
        logic [NS-1:0]          rd_c;
        logic [NS-1:0]          wr_c;
        logic [NS-1:0][DW-1:0]  addr_c;
        logic [NS-1:0][DW-1:0]  wdata_c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             bundle_valid;
    logic             bundle_ready;
    logic [NS-1:0]    op_valid;
    logic [NS-1:0]    op_we;
    logic [NS*DW-1:0] op_addr;
    logic [NS*DW-1:0] op_wdata;
    logic             done;
    logic [NS*DW-1:0] rdata;
    logic [NS-1:0]    err;
    logic             mem_rd_en;
    logic [DW-1:0]    mem_rd_addr;
    logic             mem_wr_en;
    logic [DW-1:0]    mem_wr_addr;
    logic [DW-1:0]    mem_wr_data;
    logic [DW-1:0]    mem_data_out;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem     [0:MEM_DEPTH-1];
    logic [DW-1:0] ref_mem [0:MEM_DEPTH-1];
    exp_t          exp_q   [$];

    exp_t          cur;
    bit            mon_active = 1'b0;
    int            mon_cyc    = 0;
    int            bundle_cnt = 0;
    logic          e_rd, e_wr;
    logic [DW-1:0] e_rda, e_wra, e_wrd;

    always #5 clk = ~clk;

    lsu_mem_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .bundle_valid (bundle_valid),
        .bundle_ready (bundle_ready),
        .op_valid     (op_valid),
        .op_we        (op_we),
        .op_addr      (op_addr),
        .op_wdata     (op_wdata),
        .done         (done),
        .rdata        (rdata),
        .err          (err),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_data_out (mem_data_out)
    );

    // main_memory: write at the edge, registered one-cycle read.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr[9:0]] = mem_wr_data;
        if (mem_rd_en) mem_data_out <= mem[mem_rd_addr[9:0]];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: execute the bundle's ops in slot order against ref_mem.
    task automatic model_bundle(input logic [NS-1:0] v, input logic [NS-1:0] we,
                                input logic [NS*DW-1:0] a, input logic [NS*DW-1:0] wd,
                                output exp_t e);
        int c;
        c = 0;
        e = '0;
        for (int k = 0; k < NS; k++) begin
            if (v[k]) begin
                logic [DW-1:0] ak;
                ak = a[k*DW +: DW];
                if (ak >= MEM_DEPTH) begin
                    e.err[k] = 1'b1;
                end else if (we[k]) begin
                    ref_mem[ak[9:0]] = wd[k*DW +: DW];
                    e.wr_c[c]        = 1'b1;
                    e.addr_c[c]      = ak;
                    e.wdata_c[c]     = wd[k*DW +: DW];
                end else begin
                    e.rdata[k*DW +: DW] = ref_mem[ak[9:0]];
                    e.rd_c[c]           = 1'b1;
                    e.addr_c[c]         = ak;
                end
                c++;
            end
        end
        e.n = 32'(c);
    endtask

    // Monitor: arms on an accept seen at the negedge before the accepting edge,
    // then checks every cycle of that bundle against the expected item.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active) begin
                e_rd = 1'b0; e_wr = 1'b0; e_rda = '0; e_wra = '0; e_wrd = '0;
                if (mon_cyc < NS) begin
                    e_rd = cur.rd_c[mon_cyc];
                    e_wr = cur.wr_c[mon_cyc];
                    if (e_rd) e_rda = cur.addr_c[mon_cyc];
                    if (e_wr) begin
                        e_wra = cur.addr_c[mon_cyc];
                        e_wrd = cur.wdata_c[mon_cyc];
                    end
                end
                check("rd_en", mem_rd_en, e_rd);
                check("wr_en", mem_wr_en, e_wr);
                check("rd_addr", mem_rd_addr, e_rda);
                check("wr_addr", mem_wr_addr, e_wra);
                check("wr_data", mem_wr_data, e_wrd);
                if (done) begin
                    check("done_cycle", mon_cyc, cur.n + 1);
                    check("ready_at_done", bundle_ready, 1'b1);
                    for (int k = 0; k < NS; k++) begin
                        check($sformatf("rdata[%0d]", k), rdata[k*DW +: DW], cur.rdata[k*DW +: DW]);
                    end
                    check("err", err, cur.err);
                    $display("bundle %0d: n=%0d done_cycle=%0d err=%b rdata=%h",
                             bundle_cnt, cur.n, mon_cyc, err, rdata);
                    bundle_cnt++;
                    mon_active = 1'b0;
                end else if (mon_cyc >= int'(cur.n) + 1) begin
                    checks++;
                    failures++;
                    $display("FAIL done_timeout: no done by cycle %0d, required cycle %0d", mon_cyc, cur.n + 1);
                    mon_active = 1'b0;
                end
                mon_cyc++;
            end else begin
                check("idle_done", done, 1'b0);
                check("idle_en", {mem_rd_en, mem_wr_en}, 2'b00);
            end
            if (bundle_valid && bundle_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_unexpected: accept with empty expectation queue");
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_cyc    = 0;
                end
            end
        end
    end

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Present a bundle and return just after the edge that accepts it.
    task automatic drive_bundle(input logic [NS-1:0] v, input logic [NS-1:0] we,
                                input logic [NS*DW-1:0] a, input logic [NS*DW-1:0] wd,
                                output int waited);
        exp_t e;
        model_bundle(v, we, a, wd, e);
        exp_q.push_back(e);
        op_valid     = v;
        op_we        = we;
        op_addr      = a;
        op_wdata     = wd;
        bundle_valid = 1'b1;
        waited       = 0;
        @(negedge clk);
        while (!bundle_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bundle_ready) begin
            $display("FAIL accept_timeout: bundle_ready stayed %0b after %0d cycles", bundle_ready, waited);
            failures++;
            checks++;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "accept timeout");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        int k;
        k = 0;
        bundle_valid = 1'b0;
        while ((exp_q.size() != 0 || mon_active) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", (exp_q.size() != 0 || mon_active), 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, bundle_ready, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_rdata"}, rdata, '0);
        check({tag, "_err"}, err, '0);
        check({tag, "_en"}, {mem_rd_en, mem_wr_en}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [NS-1:0]    v, we;
        logic [NS*DW-1:0] a, wd;

        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[4+i]     = 32'hA + 32'(i);
            ref_mem[4+i] = 32'hA + 32'(i);
        end
        rst = 1'b1; bundle_valid = 1'b0;
        op_valid = '0; op_we = '0; op_addr = '0; op_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Empty bundle.
        drive_bundle(4'b0000, 4'b0000, '0, '0, w);
        go_idle();

        // Four loads from the preloaded words 4..7.
        drive_bundle(4'b1111, 4'b0000, {32'd7, 32'd6, 32'd5, 32'd4}, '0, w);
        go_idle();
        check("t3_rdata", rdata, {32'hD, 32'hC, 32'hB, 32'hA});

        // Store then load of the same address within one bundle.
        drive_bundle(4'b0101, 4'b0001, {32'd0, 32'h10, 32'd0, 32'h10},
                     {32'd0, 32'd0, 32'd0, 32'hCAFE}, w);
        go_idle();
        check("t4_rdata2", rdata[2*DW +: DW], 32'hCAFE);

        // Out-of-range address on slot 1.
        drive_bundle(4'b1010, 4'b0000, {32'd3, 32'd0, 32'd2000, 32'd0}, '0, w);
        go_idle();
        check("t5_err", err, 4'b0010);
        check("t5_rdata1", rdata[1*DW +: DW], 32'h0);

        // Back-to-back bundles with bundle_valid held high.
        drive_bundle(4'b0011, 4'b0010, {32'd0, 32'd0, 32'h20, 32'h21},
                     {32'd0, 32'd0, 32'h1234, 32'd0}, w);
        drive_bundle(4'b1001, 4'b0000, {32'h20, 32'd0, 32'd0, 32'h21}, '0, w);
        check("t6_accept_gap", w, 3);
        go_idle();

        // Reset in the middle of a four-load bundle.
        drive_bundle(4'b1111, 4'b0000, {32'd7, 32'd6, 32'd5, 32'd4}, '0, w);
        bundle_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("post_rst");
        @(posedge clk);
        #1;

        // Randomised bundles, small address range to force collisions.
        for (int b = 0; b < 60; b++) begin
            v  = NS'($urandom);
            we = NS'($urandom);
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(0, 9) == 0)
                    a[k*DW +: DW] = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'(1024 + $urandom_range(0, 5000));
                else
                    a[k*DW +: DW] = 32'($urandom_range(0, 15));
                wd[k*DW +: DW] = $urandom;
            end
            drive_bundle(v, we, a, wd, w);
            if ($urandom_range(0, 2) == 0) go_idle();
        end
        go_idle();

        begin
            int mism;
            mism = 0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                if (mem[i] !== ref_mem[i]) mism++;
            end
            check("mem_final_mismatches", mism, 0);
        end
        finish_run();
    end

endmodule
